// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The master side drives the digits and start; the slave side returns the result.
interface bcd_to_bin_if;
  logic        start;
  logic [3:0]  hundred_thousands_in;
  logic [3:0]  ten_thousands_in;
  logic [3:0]  thousands_in;
  logic [3:0]  hundreds_in;
  logic [3:0]  tens_in;
  logic [3:0]  units_in;
  logic [19:0] bin_out;
  logic        busy;
  logic        done;
  logic        digit_err;

  modport master (
    output start, hundred_thousands_in, ten_thousands_in, thousands_in,
           hundreds_in, tens_in, units_in,
    input  bin_out, busy, done, digit_err
  );

  modport slave (
    input  start, hundred_thousands_in, ten_thousands_in, thousands_in,
           hundreds_in, tens_in, units_in,
    output bin_out, busy, done, digit_err
  );
endinterface

// File: rtl/bcd_to_bin_converter.sv
// Six-digit packed BCD to 20-bit binary, one digit folded per clock (acc*10 + digit).
// Fixed 7-cycle start-to-done latency, including conversions with invalid digits.
module bcd_to_bin_converter (
  input  logic          clk,
  input  logic          rst_n,
  bcd_to_bin_if.slave   bus
);
  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, FINISH = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [NUM_DIGITS-1:0][3:0] digits_in;
  logic [NUM_DIGITS-1:0]      dig_bad;
  logic [23:0]     dig_sr;
  logic [19:0]     acc;
  logic [23:0]     acc_nxt;
  logic [2:0]      cnt;
  logic            err_flag;
  logic [19:0]     bin_q;
  logic            busy_q, done_q, err_q;

  assign digits_in = {bus.hundred_thousands_in, bus.ten_thousands_in, bus.thousands_in,
                      bus.hundreds_in, bus.tens_in, bus.units_in};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_chk
    assign dig_bad[i] = (digits_in[i] > 4'd9);
  end

  // acc*10 built from shifts in 24 bits; valid input never exceeds 20 bits
  assign acc_nxt = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {20'b0, dig_sr[23:20]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CONV;
      CONV:    if (cnt == 3'd5) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sr   <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      bin_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          dig_sr   <= digits_in;
          acc      <= '0;
          cnt      <= '0;
          err_flag <= |dig_bad;
          busy_q   <= 1'b1;
        end
        CONV: begin
          acc    <= acc_nxt[19:0];
          dig_sr <= {dig_sr[19:0], 4'h0};
          cnt    <= cnt + 3'd1;
        end
        FINISH: begin
          bin_q  <= err_flag ? 20'd0 : acc;
          err_q  <= err_flag;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.digit_err = err_q;
endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Bench for bcd_to_bin_converter: fixed vector table, hand sequences for
// back-to-back/ignored-start/reset-abort, and random digits against a decimal model.
module tb_bcd_to_bin_converter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bcd_to_bin_if bus();

  bcd_to_bin_converter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;

  typedef struct {
    logic [5:0][3:0] d;
    logic [19:0]     exp_bin;
    logic            exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Decimal place-value model
  function automatic void model(input logic [5:0][3:0] d, output logic [19:0] v, output logic e);
    int unsigned sum = 0;
    int unsigned w = 1;
    e = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (d[i] > 9) e = 1'b1;
      sum += d[i] * w;
      w *= 10;
    end
    v = e ? 20'd0 : sum[19:0];
  endfunction

  task automatic drive_digits(input logic [5:0][3:0] d);
    bus.hundred_thousands_in = d[5];
    bus.ten_thousands_in     = d[4];
    bus.thousands_in         = d[3];
    bus.hundreds_in          = d[2];
    bus.tens_in              = d[1];
    bus.units_in             = d[0];
  endtask

  // Caller is at a negedge; returns at the negedge where done is observed.
  task automatic convert(input logic [5:0][3:0] d, input logic [19:0] exp_bin, input logic exp_err);
    int k;
    bit got = 0;
    drive_digits(d);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("done_low_after_start", bus.done, 0);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin got = 1; break; end
      if (bus.busy !== 1'b1) check("busy_during_conv", bus.busy, 1);
    end
    if (!got) check("done_timeout", 0, 1);
    else begin
      check("latency", k, 7);
      check("busy_at_done", bus.busy, 0);
      check("bin_out", bus.bin_out, exp_bin);
      check("digit_err", bus.digit_err, exp_err);
    end
  endtask

  initial begin
    vec_t tbl[8];
    logic [5:0][3:0] d;
    logic [19:0] mv;
    logic me;
    int ndone;

    tbl[0] = '{d: 24'h000000, exp_bin: 20'h00000, exp_err: 1'b0};
    tbl[1] = '{d: 24'h123456, exp_bin: 20'h1E240, exp_err: 1'b0};
    tbl[2] = '{d: 24'h999999, exp_bin: 20'hF423F, exp_err: 1'b0};
    tbl[3] = '{d: 24'h0000A0, exp_bin: 20'h00000, exp_err: 1'b1};
    tbl[4] = '{d: 24'h000042, exp_bin: 20'd42,    exp_err: 1'b0};
    tbl[5] = '{d: 24'h100000, exp_bin: 20'd100000, exp_err: 1'b0};
    tbl[6] = '{d: 24'hF00001, exp_bin: 20'h00000, exp_err: 1'b1};
    tbl[7] = '{d: 24'h090807, exp_bin: 20'd90807, exp_err: 1'b0};

    bus.start = 1'b0;
    drive_digits(24'h0);
    #12;
    check("rst_bin_out", bus.bin_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_digit_err", bus.digit_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table entries run back-to-back: each start lands in the previous done cycle
    for (int i = 0; i < 8; i++) convert(tbl[i].d, tbl[i].exp_bin, tbl[i].exp_err);
    @(negedge clk);
    check("done_single_cycle", bus.done, 0);

    // Inputs changed and start re-pulsed mid-conversion: both ignored
    drive_digits(24'h100000);
    bus.start = 1'b1;
    @(negedge clk);                      // edge N
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) drive_digits(24'h987654);
      if (k == 2) bus.start = 1'b1;      // high across edge N+3
      if (k == 3) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("ign_latency", k, 7);
        check("ign_bin_out", bus.bin_out, 20'd100000);
      end
    end
    check("ign_done_count", ndone, 1);

    // Reset mid-conversion aborts with no done
    drive_digits(24'h123456);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;                  // just after edge N+4
    rst_n = 1'b0;
    #1;
    check("abort_bin_out", bus.bin_out, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_digit_err", bus.digit_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    convert(24'h000007, 20'd7, 1'b0);

    // Random digits, roughly one in four conversions carrying a bad digit
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 6; i++)
        d[i] = (($urandom % 24) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      model(d, mv, me);
      if ($urandom % 2) @(negedge clk);
      convert(d, mv, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nmis);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_converter.md
# bcd_to_bin_converter

Sequential converter from six packed BCD digits (hundred-thousands down to units) to a 20-bit unsigned binary value. It is the inverse of the counter's binary-to-BCD/rounding path. It lets rounded display values, or user-entered BCD settings such as gate-time and threshold presets, return to the binary arithmetic domain of the frequency counter. One digit is folded per clock (acc = acc*10 + digit), with a start/done handshake and invalid-digit detection.

## Interface
- No parameters; digit count fixed at 6, output width fixed at 20 bits (max 999999 = 0xF423F).
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request conversion; sampled only in IDLE
- hundred_thousands_in  input  4  BCD digit 5 (most significant)
- ten_thousands_in  input  4  BCD digit 4
- thousands_in  input  4  BCD digit 3
- hundreds_in  input  4  BCD digit 2
- tens_in  input  4  BCD digit 1
- units_in  input  4  BCD digit 0 (least significant)
- bin_out  output  20  converted value; held until next completion
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: bin_out/digit_err updated
- digit_err  output  1  last conversion saw a digit > 9; held until next completion

## Operation
- States: IDLE, CONV, FINISH.
- IDLE:
  - start=1 at an edge: capture all six digits into an internal 24-bit shift register (MS digit at top).
  - Clear the 20-bit accumulator and the 3-bit digit counter.
  - Set err_flag if any captured digit > 9; busy<=1; go to CONV.
  - start=0: stay in IDLE.
- CONV, each edge:
  - acc <= acc*10 + top digit, with acc*10 formed as (acc<<3)+(acc<<1) in ≥24-bit width, result truncated to 20 bits.
  - Shift the digit register left by 4; counter +1.
  - After the 6th accumulate (counter 5→6), go to FINISH.
- FINISH, one edge:
  - bin_out <= err_flag ? 0 : acc; digit_err <= err_flag; done <= 1; busy <= 0; go to IDLE.
- Invalid digits still take the full 6 CONV cycles (constant latency); any acc value computed from them is discarded.
- Inputs are sampled only at the start edge; later changes have no effect on the running conversion.
- start while busy (CONV or FINISH) is ignored, not queued.
- Range: valid input never exceeds 999999, so no overflow path exists.

## Timing
- Reset (async assert, any state): state=IDLE, bin_out=0, busy=0, done=0, digit_err=0, acc/counter/err_flag=0.
- Reset asserted mid-conversion aborts it; no done is produced.
- start sampled high at edge N: busy=1 from N, CONV accumulates on edges N+1..N+6, FINISH at edge N+7.
- After edge N+7: done=1, busy=0, bin_out valid for one cycle of done; done returns to 0 at edge N+8.
- Latency start edge → done edge: 7 cycles.
- Back-to-back: start may be high during the done cycle (state IDLE) and is accepted at edge N+8, giving 8-cycle throughput.
- done is never asserted for two consecutive cycles.
- done is never asserted without a prior accepted start.

## Test plan
- Digits 0,0,0,0,0,0, start pulse at edge N → done at N+7, bin_out=0x00000, digit_err=0, busy high exactly edges N..N+7.
- Digits 1,2,3,4,5,6 → bin_out=0x1E240 (123456), digit_err=0. Then 9,9,9,9,9,9 issued back-to-back (start during the done cycle) → bin_out=0xF423F, done 8 cycles after the first.
- Tens digit 0xA, others 0 → done at N+7 with digit_err=1, bin_out=0. A following valid conversion of 0,0,0,0,4,2 → bin_out=42, digit_err cleared.
- Start 1,0,0,0,0,0, then pulse start again at N+3 with different digits and change the digit inputs at N+1 → single done at N+7, bin_out=100000 (0x186A0), second start ignored.
- Start conversion, assert rst_n low at N+4 → all outputs 0 immediately, no done pulse. After release, a new start with 0,0,0,0,0,7 → bin_out=7 after 7 cycles.
